// File: rtl/video_overlay.sv
// Purpose : re-emits the VGA timing/RGB stream and draws a bouncing solid box over the active area.
// Latency : exactly 1 pixel_clk for out_hs/out_vs/out_blank/out_rgb.
// Backpressure: none; the stage never stalls and consumes one pixel per clock.
//
// Ports:
//   pixel_clk, pixel_rst  : pixel clock and synchronous active-high reset
//   enable                : 1 = draw and move the box, 0 = pure pass-through (position frozen)
//   in_hs/in_vs/in_blank/in_rgb   : upstream timing (syncs active low, blank=1 means active pixel)
//   out_hs/out_vs/out_blank/out_rgb : same stream one clock later, with the overlay applied
//   box_x, box_y          : current top-left corner of the box
//   frame_cnt             : number of in_vs falling edges seen, wrapping at 16 bits
//
// Build option: define OVERLAY_GRID_EN to add a 16-pixel grey grid underneath the box.

module video_overlay #(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter int          BOX_W     = 32,
  parameter int          BOX_H     = 32,
  parameter int          STEP      = 4,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
  input  logic                       pixel_clk,
  input  logic                       pixel_rst,
  input  logic                       enable,
  input  logic                       in_hs,
  input  logic                       in_vs,
  input  logic                       in_blank,
  input  logic [23:0]                in_rgb,
  output logic                       out_hs,
  output logic                       out_vs,
  output logic                       out_blank,
  output logic [23:0]                out_rgb,
  output logic [$clog2(HDISP)-1:0]   box_x,
  output logic [$clog2(VDISP)-1:0]   box_y,
  output logic [15:0]                frame_cnt
);

  localparam int XW  = $clog2(HDISP);
  localparam int YW  = $clog2(VDISP);
  // Counter/compare widths leave headroom so box_pos + BOX_W never wraps.
  localparam int CW  = $clog2(HDISP + BOX_W + 1);
  localparam int YCW = $clog2(VDISP + BOX_H + 1);

  localparam logic [CW-1:0]  X_MAX_C  = CW'(HDISP - BOX_W);
  localparam logic [YCW-1:0] Y_MAX_C  = YCW'(VDISP - BOX_H);
  localparam logic [CW-1:0]  X_STEP_C = CW'(STEP);
  localparam logic [YCW-1:0] Y_STEP_C = YCW'(STEP);
  localparam logic [CW-1:0]  BOX_W_C  = CW'(BOX_W);
  localparam logic [YCW-1:0] BOX_H_C  = YCW'(BOX_H);
  localparam logic [YCW-1:0] VDISP_C  = YCW'(VDISP);

  typedef enum logic {
    WAIT_VS = 1'b0,
    MOVE    = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    x_cnt;
  logic [YCW-1:0]   y_cnt;
  logic             dir_x_neg, dir_y_neg;
  logic             dir_x_neg_nxt, dir_y_neg_nxt;
  logic [XW-1:0]    box_x_nxt;
  logic [YW-1:0]    box_y_nxt;
  logic [23:0]      rgb_nxt;
  logic             in_box;
  logic             vs_fall, blank_fall;

  // out_vs and out_blank are exactly the previous-cycle inputs, so they double
  // as the edge-detect history (reset values 1 and 0 match the required history).
  assign vs_fall    = out_vs & ~in_vs;
  assign blank_fall = out_blank & ~in_blank;

  // ---------------------------------------------------------------- pixel rule
  assign in_box = (x_cnt >= CW'(box_x)) && (x_cnt < CW'(box_x) + BOX_W_C) &&
                  (y_cnt >= YCW'(box_y)) && (y_cnt < YCW'(box_y) + BOX_H_C);

`ifdef OVERLAY_GRID_EN
  logic on_grid;
  assign on_grid = (x_cnt[3:0] == 4'd0) || (y_cnt[3:0] == 4'd0);
`endif

  always_comb begin
    rgb_nxt = in_rgb;
    if (!in_blank) begin
      rgb_nxt = 24'h000000;
    end else if (enable && in_box) begin
      rgb_nxt = BOX_COLOR;
`ifdef OVERLAY_GRID_EN
    end else if (enable && on_grid) begin
      rgb_nxt = 24'h404040;
`endif
    end
  end

  // ---------------------------------------------------------------- motion FSM
  always_comb begin
    state_nxt     = state;
    box_x_nxt     = box_x;
    box_y_nxt     = box_y;
    dir_x_neg_nxt = dir_x_neg;
    dir_y_neg_nxt = dir_y_neg;
    case (state)
      WAIT_VS: begin
        if (vs_fall && enable) begin
          state_nxt = MOVE;
        end
      end
      MOVE: begin
        state_nxt = WAIT_VS;
        // Horizontal axis: clamp at the edge and reverse in the same move.
        if (!dir_x_neg) begin
          if (CW'(box_x) + X_STEP_C >= X_MAX_C) begin
            box_x_nxt     = XW'(X_MAX_C);
            dir_x_neg_nxt = 1'b1;
          end else begin
            box_x_nxt = box_x + XW'(STEP);
          end
        end else begin
          if (CW'(box_x) <= X_STEP_C) begin
            box_x_nxt     = '0;
            dir_x_neg_nxt = 1'b0;
          end else begin
            box_x_nxt = box_x - XW'(STEP);
          end
        end
        // Vertical axis, same rule.
        if (!dir_y_neg) begin
          if (YCW'(box_y) + Y_STEP_C >= Y_MAX_C) begin
            box_y_nxt     = YW'(Y_MAX_C);
            dir_y_neg_nxt = 1'b1;
          end else begin
            box_y_nxt = box_y + YW'(STEP);
          end
        end else begin
          if (YCW'(box_y) <= Y_STEP_C) begin
            box_y_nxt     = '0;
            dir_y_neg_nxt = 1'b0;
          end else begin
            box_y_nxt = box_y - YW'(STEP);
          end
        end
      end
      default: state_nxt = WAIT_VS;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state <= WAIT_VS;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      out_hs    <= 1'b1;
      out_vs    <= 1'b1;
      out_blank <= 1'b0;
      out_rgb   <= 24'h000000;
      x_cnt     <= '0;
      y_cnt     <= '0;
      box_x     <= '0;
      box_y     <= '0;
      dir_x_neg <= 1'b0;
      dir_y_neg <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      out_hs    <= in_hs;
      out_vs    <= in_vs;
      out_blank <= in_blank;
      out_rgb   <= rgb_nxt;

      if (blank_fall) begin
        x_cnt <= '0;
      end else if (in_blank) begin
        x_cnt <= x_cnt + CW'(1);
      end

      // VS has priority over the end-of-line increment when both fall together.
      if (vs_fall) begin
        y_cnt <= '0;
      end else if (blank_fall && (y_cnt != VDISP_C)) begin
        y_cnt <= y_cnt + YCW'(1);
      end

      // A VS edge can never land in the single MOVE cycle (VS must rise first),
      // so counting on every falling edge equals counting from WAIT_VS.
      if (vs_fall) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      box_x     <= box_x_nxt;
      box_y     <= box_y_nxt;
      dir_x_neg <= dir_x_neg_nxt;
      dir_y_neg <= dir_y_neg_nxt;
    end
  end

endmodule

// File: tb/tb_video_overlay.sv
// Purpose : randomized self-checking bench for video_overlay against a coordinate-level model.
// Latency : model expects every out_* one clock after the inputs that produce it.
// Backpressure: none; stimulus is one pixel per clock.

module tb_video_overlay;

  localparam int          HDISP     = 800;
  localparam int          VDISP     = 480;
  localparam int          BOX_W     = 32;
  localparam int          BOX_H     = 32;
  localparam int          STEP      = 4;
  localparam logic [23:0] BOX_COLOR = 24'hFF0000;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst = 1'b0;
  logic        enable    = 1'b0;
  logic        in_hs     = 1'b1;
  logic        in_vs     = 1'b1;
  logic        in_blank  = 1'b0;
  logic [23:0] in_rgb    = 24'h0;
  logic        out_hs, out_vs, out_blank;
  logic [23:0] out_rgb;
  logic [9:0]  box_x;
  logic [8:0]  box_y;
  logic [15:0] frame_cnt;

  video_overlay #(
    .HDISP(HDISP), .VDISP(VDISP), .BOX_W(BOX_W), .BOX_H(BOX_H),
    .STEP(STEP), .BOX_COLOR(BOX_COLOR)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .enable(enable),
    .in_hs(in_hs), .in_vs(in_vs), .in_blank(in_blank), .in_rgb(in_rgb),
    .out_hs(out_hs), .out_vs(out_vs), .out_blank(out_blank), .out_rgb(out_rgb),
    .box_x(box_x), .box_y(box_y), .frame_cnt(frame_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: number of box moves and VS edges since reset.
  int  moves      = 0;
  int  frames     = 0;
  bit  m_prev_vs  = 1'b1;
  bit  cur_en     = 1'b0;

  // Expected outputs for the cycle currently visible on the DUT outputs.
  bit          exp_valid = 1'b0;
  logic        exp_hs, exp_vs, exp_blank;
  logic [23:0] exp_rgb;

  logic [23:0] drv_rgb [0:63][0:127];
  logic [23:0] got_rgb [0:63][0:127];

  // Box position after n moves: a triangle wave between 0 and maxp.
  function automatic int tri_pos(input int n, input int maxp);
    int p, k;
    p = maxp / STEP;
    k = n % (2 * p);
    return (k <= p) ? k * STEP : (2 * p - k) * STEP;
  endfunction

  function automatic logic [23:0] model_rgb(input bit en, input bit blank, input int c,
                                            input int l, input logic [23:0] rgb);
    int bx, by;
    bx = tri_pos(moves, HDISP - BOX_W);
    by = tri_pos(moves, VDISP - BOX_H);
    if (!blank) return 24'h0;
    if (en && c >= bx && c < bx + BOX_W && l >= by && l < by + BOX_H) return BOX_COLOR;
`ifdef OVERLAY_GRID_EN
    if (en && ((c % 16) == 0 || (l % 16) == 0)) return 24'h404040;
`endif
    return rgb;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive one clock of stimulus; returns #1 after the edge that captured it.
  task automatic apply(input bit rst, input bit hs, input bit vs, input bit blank,
                       input logic [23:0] rgb, input int c, input int l);
    logic        e_hs, e_vs, e_blank;
    logic [23:0] e_rgb;
    pixel_rst = rst;
    enable    = cur_en;
    in_hs     = hs;
    in_vs     = vs;
    in_blank  = blank;
    in_rgb    = rgb;
    if (rst) begin
      e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0; e_rgb = 24'h0;
      moves = 0; frames = 0; m_prev_vs = 1'b1;
    end else begin
      e_hs = hs; e_vs = vs; e_blank = blank;
      e_rgb = model_rgb(cur_en, blank, c, l, rgb);
      if (m_prev_vs && !vs) begin
        frames++;
        if (cur_en) moves++;
      end
      m_prev_vs = vs;
    end
    @(posedge pixel_clk);
    #1;
    exp_hs = e_hs; exp_vs = e_vs; exp_blank = e_blank; exp_rgb = e_rgb;
    exp_valid = 1'b1;
  endtask

  // Every cycle: compare the registered stream against the model.
  always @(negedge pixel_clk) begin
    if (exp_valid) begin
      n_tests++;
      if (out_hs !== exp_hs || out_vs !== exp_vs || out_blank !== exp_blank ||
          out_rgb !== exp_rgb) begin
        n_fail++;
        if (n_fail < 20)
          $display("FAIL stream @%0t: got hs=%b vs=%b blank=%b rgb=%h, required hs=%b vs=%b blank=%b rgb=%h",
                   $time, out_hs, out_vs, out_blank, out_rgb, exp_hs, exp_vs, exp_blank, exp_rgb);
      end
    end
  end

  task automatic reset_n(input int n);
    for (int i = 0; i < n; i++)
      apply(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 24'($urandom), 0, 0);
  endtask

  // One frame: active lines with short HS blanking, then vblank with a VS pulse.
  task automatic frame(input int lines, input int pix, input int tog_line,
                       input int rst_line, input int rst_col);
    logic [23:0] rgb;
    for (int l = 0; l < lines; l++) begin
      if (l == tog_line) cur_en = !cur_en;
      for (int c = 0; c < pix; c++) begin
        rgb = 24'($urandom);
        drv_rgb[l][c] = rgb;
        if (l == rst_line && c == rst_col) begin
          apply(1'b1, 1'b1, 1'b1, 1'b1, rgb, c, l);
          chk("midrst_out_blank", 32'(out_blank), 32'd0);
          chk("midrst_out_rgb", 32'(out_rgb), 32'd0);
          chk("midrst_box_x", 32'(box_x), 32'd0);
          chk("midrst_box_y", 32'(box_y), 32'd0);
          chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
          repeat (3) apply(1'b0, 1'b1, 1'b1, 1'b0, 24'($urandom), 0, 0);
          return;
        end
        apply(1'b0, 1'b1, 1'b1, 1'b1, rgb, c, l);
        got_rgb[l][c] = out_rgb;
      end
      apply(1'b0, 1'b1, 1'b1, 1'b0, 24'($urandom), 0, l);
      apply(1'b0, 1'b0, 1'b1, 1'b0, 24'($urandom), 0, l);
      apply(1'b0, 1'b1, 1'b1, 1'b0, 24'($urandom), 0, l);
    end
    apply(1'b0, 1'b1, 1'b1, 1'b0, 24'($urandom), 0, 0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 24'($urandom), 0, 0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 24'($urandom), 0, 0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 24'($urandom), 0, 0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 24'($urandom), 0, 0);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_box_x"}, 32'(box_x), 32'(tri_pos(moves, HDISP - BOX_W)));
    chk({tag, "_box_y"}, 32'(box_y), 32'(tri_pos(moves, VDISP - BOX_H)));
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(frames & 16'hFFFF));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs.
    reset_n(3);
    chk("rst_out_hs", 32'(out_hs), 32'd1);
    chk("rst_out_vs", 32'(out_vs), 32'd1);
    chk("rst_out_blank", 32'(out_blank), 32'd0);
    chk("rst_out_rgb", 32'(out_rgb), 32'd0);
    chk("rst_box_x", 32'(box_x), 32'd0);
    chk("rst_box_y", 32'(box_y), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    // Pass-through with enable=0.
    cur_en = 1'b0;
    apply(1'b0, 1'b1, 1'b1, 1'b1, 24'h123456, 0, 0);
    chk("pass_rgb", 32'(out_rgb), 32'h123456);
    chk("pass_blank", 32'(out_blank), 32'd1);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 24'hABCDEF, 0, 0);
    chk("pass_hs_low", 32'(out_hs), 32'd0);
    chk("pass_blank_rgb", 32'(out_rgb), 32'd0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 0, 0);
    chk("pass_hs_high", 32'(out_hs), 32'd1);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 0, 0);
    chk("pass_vs_low", 32'(out_vs), 32'd0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 0, 0);
    chk("pass_vs_high", 32'(out_vs), 32'd1);
    chk("pass_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("pass_box_x", 32'(box_x), 32'd0);

    // Box draw on frame 0, then motion from reset.
    reset_n(3);
    cur_en = 1'b1;
    frame(34, 34, -1, -1, -1);
    chk("draw_0_0", 32'(got_rgb[0][0]), 32'hFF0000);
    chk("draw_31_31", 32'(got_rgb[31][31]), 32'hFF0000);
    chk("draw_32_0", 32'(got_rgb[0][32]), 32'(drv_rgb[0][32]));
    chk("draw_0_32", 32'(got_rgb[32][0]), 32'(drv_rgb[32][0]));
    chk("move1_box_x", 32'(box_x), 32'd4);
    chk("move1_box_y", 32'(box_y), 32'd4);
    for (int f = 2; f <= 193; f++) begin
      frame(1, 4, -1, -1, -1);
      chk_model("motion");
      if (f == 112) chk("f112_box_y", 32'(box_y), 32'd448);
      if (f == 113) chk("f113_box_y", 32'(box_y), 32'd444);
      if (f == 192) chk("f192_box_x", 32'(box_x), 32'd768);
      if (f == 193) begin
        chk("f193_box_x", 32'(box_x), 32'd764);
        chk("f193_frame_cnt", 32'(frame_cnt), 32'd193);
      end
    end

    // Random frames: sizes, enable, occasional mid-frame enable flip.
    for (int i = 0; i < 10; i++) begin
      int ln;
      cur_en = ($urandom_range(0, 3) != 0);
      ln = $urandom_range(1, 24);
      frame(ln, $urandom_range(1, 64),
            ($urandom_range(0, 2) == 0) ? $urandom_range(0, ln - 1) : -1, -1, -1);
      chk_model("rand");
    end

    // Reset during an active line, then a clean frame from (0,0).
    cur_en = 1'b1;
    frame(20, 40, -1, 5, 10);
    frame(34, 34, -1, -1, -1);
    chk("postrst_0_0", 32'(got_rgb[0][0]), 32'hFF0000);
    chk("postrst_31_31", 32'(got_rgb[31][31]), 32'hFF0000);
    chk("postrst_32_0", 32'(got_rgb[0][32]), 32'(drv_rgb[0][32]));
    chk_model("postrst");

    // Grid option.
    reset_n(3);
    cur_en = 1'b1;
    frame(12, 52, -1, -1, -1);
`ifdef OVERLAY_GRID_EN
    chk("grid_48_5", 32'(got_rgb[5][48]), 32'h404040);
    chk("grid_49_5", 32'(got_rgb[5][49]), 32'(drv_rgb[5][49]));
`else
    chk("nogrid_48_5", 32'(got_rgb[5][48]), 32'(drv_rgb[5][48]));
`endif
    chk("grid_box_10_10", 32'(got_rgb[10][10]), 32'hFF0000);

    exp_valid = 1'b0;
    @(negedge pixel_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
